// File: rtl/conv_window_sequencer_pkg.sv
// Shared definitions for the convolution window sequencer: state encoding
// and default field widths for the DCNN datapath.
package conv_window_sequencer_pkg;

  localparam int CNT_W_DEF = 5;  // image side / coordinate width (max 31x31)
  localparam int K_W_DEF   = 3;  // kernel side width (max 7x7)

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/conv_window_sequencer_seq_counter.sv
// Up counter that wraps to zero after reaching a programmable last value.
// wrap flags the enabled step that rolls over so a second instance can cascade.
module seq_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic [W-1:0] q,
  output logic         wrap
);

  logic at_last;

  assign at_last = (q == last);
  assign wrap    = en & at_last;

  // Synchronous clear has priority over counting; wrap back to zero at last.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= at_last ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks the output map row-major and offers each window origin (row, col)
// to the fetch/MAC stage.
//
// Handshake: win_valid is high for the whole RUN state and win_row/win_col
// hold steady until a transfer, which is win_valid & win_ready at a rising
// edge; one transfer per cycle is possible.
module conv_window_sequencer
  import conv_window_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int K_W   = K_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_img_size,
  input  logic [K_W-1:0]   cfg_k_size,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [CNT_W-1:0] win_row,
  output logic [CNT_W-1:0] win_col,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output seq_state_t       state_dbg
);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] last_q;
  logic             err_q;

  logic [CNT_W-1:0] k_ext;
  logic             cfg_bad;
  logic             accept;
  logic             xfer;
  logic             cnt_clr;
  logic             col_wrap;
  logic             row_wrap;

  assign k_ext   = {{(CNT_W-K_W){1'b0}}, cfg_k_size};
  assign cfg_bad = (cfg_k_size == '0) || (k_ext > cfg_img_size);
  assign accept  = (state_q == ST_IDLE) && start;
  assign xfer    = win_valid & win_ready;
  // Counters sit at zero outside RUN so FIN and IDLE present origin (0,0).
  assign cnt_clr = rst || (state_q != ST_RUN);

  seq_counter #(.W(CNT_W)) u_col (
    .clk  (clk),
    .en   (xfer),
    .clr  (cnt_clr),
    .last (last_q),
    .q    (win_col),
    .wrap (col_wrap)
  );

  seq_counter #(.W(CNT_W)) u_row (
    .clk  (clk),
    .en   (col_wrap),
    .clr  (cnt_clr),
    .last (last_q),
    .q    (win_row),
    .wrap (row_wrap)
  );

  // State register plus the config latched when a pass is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_q <= cfg_img_size - k_ext;
      end
      err_q <= accept && cfg_bad;
    end
  end

  // Next-state: bad config skips straight to FIN; RUN ends on the final window.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = cfg_bad ? ST_FIN : ST_RUN;
      ST_RUN:  if (row_wrap) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign win_valid = (state_q == ST_RUN);
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_FIN);
  assign cfg_err   = err_q;
  assign state_dbg = state_q;

endmodule
